sel_sort_ctrl: RTL and testbench
================================

SEL_SORT_CTRL -- requirements
Module: sel_sort_ctrl

Interface
REQ-001 SHALL have parameter SIZE_ADDR, default 8, RAM address width.
REQ-002 SHALL have parameter SIZE_DATA, default 8, RAM data width (unsigned).
REQ-003 SHALL have port i_clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_start  in  1  start-sort request, sampled in IDLE only.
REQ-006 SHALL have port i_last_addr  in  SIZE_ADDR  index of last element (N-1), captured on accepted start.
REQ-007 SHALL have port o_busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port o_done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port o_ram_rd_en  out  1  RAM read strobe, data returned next cycle.
REQ-010 SHALL have port o_ram_addr  out  SIZE_ADDR  RAM read address.
REQ-011 SHALL have port i_ram_rdata  in  SIZE_DATA  RAM read data, valid one cycle after o_ram_rd_en.
REQ-012 SHALL have port o_ram_owner  out  1  RAM port mux select: 0 = controller, 1 = swap unit.
REQ-013 SHALL have port o_swap_start  out  1  one-cycle pulse launching swap unit read sequence.
REQ-014 SHALL have port o_swap_addr_i  out  SIZE_ADDR  outer index i, held stable until i_swap_done.
REQ-015 SHALL have port o_swap_addr_smallest  out  SIZE_ADDR  index of minimum, held stable until i_swap_done.
REQ-016 SHALL have port i_swap_done  in  1  swap unit write-completion pulse.

Function
REQ-017 SHALL implement FSM IDLE, RD_I, CAP_I, RD_J, CMP_J, DECIDE, SWAP_WAIT, NEXT_I, DONE.
REQ-018 IDLE: i_start=1 and i_last_addr!=0 -> RD_I with i=0; i_start=1 and i_last_addr=0 -> DONE; otherwise stay.
REQ-019 RD_I: o_ram_rd_en=1, o_ram_addr=i, j<=i+1 -> CAP_I.
REQ-020 CAP_I: min_val<=i_ram_rdata, min_addr<=i -> RD_J.
REQ-021 RD_J: o_ram_rd_en=1, o_ram_addr=j -> CMP_J.
REQ-022 CMP_J: if i_ram_rdata < min_val (unsigned, strict) then min_val<=i_ram_rdata, min_addr<=j; j==last -> DECIDE, else j<=j+1 -> RD_J.
REQ-023 Ties SHALL keep the earlier index (no swap on equal values).
REQ-024 DECIDE: min_addr!=i -> assert o_swap_start one cycle, o_ram_owner<=1 -> SWAP_WAIT; min_addr==i -> NEXT_I, no swap.
REQ-025 SWAP_WAIT: hold o_ram_owner=1 and swap addresses until i_swap_done=1, then o_ram_owner<=0 -> NEXT_I; no timeout.
REQ-026 NEXT_I: i==last-1 -> DONE, else i<=i+1 -> RD_I.
REQ-027 DONE: o_done=1 for exactly one cycle -> IDLE.
REQ-028 o_ram_rd_en SHALL be 0 whenever o_ram_owner=1.
REQ-029 i_start while o_busy=1 SHALL be ignored; i_swap_done outside SWAP_WAIT SHALL be ignored.
REQ-030 i_last_addr changes after capture SHALL not affect the running sort.
REQ-031 Index counters SHALL never wrap: j stops at last, i stops at last-1 (last=2^SIZE_ADDR-1 legal).

Reset
REQ-032 On i_rst_n=0 FSM -> IDLE asynchronously, including mid-sort or mid-swap; no resume.
REQ-033 Reset values: o_busy, o_done, o_ram_rd_en, o_ram_owner, o_swap_start = 0; o_ram_addr, o_swap_addr_i, o_swap_addr_smallest, i, j, min_val, min_addr = 0.

Structure
REQ-034 Package sel_sort_pkg SHALL hold the FSM state enum typedef and the owner encodings OWNER_CTRL=0, OWNER_SWAP=1.
REQ-035 Sub-module sel_sort_min_tracker SHALL hold min_val/min_addr with load (CAP_I) and conditional-update (CMP_J) controls.
REQ-036 Controller SHALL contain no RAM storage; RAM port muxing is done outside using o_ram_owner.

Verification
REQ-037 last=1, RAM={3,7}, start -> no o_swap_start, o_done high exactly 7 cycles after start-accept cycle.
REQ-038 last=1, RAM={9,2} with behavioural swap model -> one o_swap_start with addr_i=0, addr_smallest=1; final RAM={2,9}.
REQ-039 last=4, RAM={5,1,4,1,3} -> swaps (0,1),(1,3),(2,4),(3,4) in order; final {1,1,3,4,5}; tie keeps index 1.
REQ-040 last=0, start -> o_done pulse next cycle, no RAM reads, no swap.
REQ-041 Reset asserted during SWAP_WAIT -> all outputs 0 immediately; i_swap_done afterwards ignored; new start sorts correctly.
REQ-042 i_start pulsed while busy and i_swap_done pulsed in RD_J -> no state disturbance, final RAM identical to undisturbed run.

Source files
------------

// File: rtl/sel_sort_pkg.sv
// Shared types for the selection-sort controller: FSM state encoding and RAM owner codes.
package sel_sort_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_I,
        ST_CAP_I,
        ST_RD_J,
        ST_CMP_J,
        ST_DECIDE,
        ST_SWAP_WAIT,
        ST_NEXT_I,
        ST_DONE
    } state_t;

    localparam logic OWNER_CTRL = 1'b0;
    localparam logic OWNER_SWAP = 1'b1;

endpackage

// File: rtl/sel_sort_min_tracker.sv
// Running minimum of the inner scan. The minimum value and its index live here.
// load_i seeds both from element i. cmp_i replaces them only on a strictly smaller
// value, so equal values keep the earlier index.
module sel_sort_min_tracker
    import sel_sort_pkg::*;
#(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 load_i,
    input  logic                 cmp_i,
    input  logic [SIZE_DATA-1:0] data_i,
    input  logic [SIZE_ADDR-1:0] addr_i,
    output logic [SIZE_ADDR-1:0] min_addr_o
);

    logic [SIZE_DATA-1:0] min_val_q;
    logic [SIZE_ADDR-1:0] min_addr_q;

    // Seed on load; on compare, take the new element only if it is strictly smaller.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            min_val_q  <= '0;
            min_addr_q <= '0;
        end else if (load_i) begin
            min_val_q  <= data_i;
            min_addr_q <= addr_i;
        end else if (cmp_i && (data_i < min_val_q)) begin
            min_val_q  <= data_i;
            min_addr_q <= addr_i;
        end
    end

    assign min_addr_o = min_addr_q;

endmodule

// File: rtl/sel_sort_ctrl.sv
// Selection-sort sequencer for an external single-port RAM. The controller only issues
// reads. Each exchange is handed to an external swap unit, and the RAM port is passed
// to that unit through o_ram_owner.
//
// state      | meaning
// IDLE       | waiting for i_start
// RD_I       | read element i, set j = i + 1
// CAP_I      | seed minimum with element i
// RD_J       | read element j
// CMP_J      | fold element j into minimum, advance j or finish scan
// DECIDE     | launch swap if minimum is not at i
// SWAP_WAIT  | RAM owned by swap unit until i_swap_done
// NEXT_I     | advance i or finish
// DONE       | one-cycle completion pulse
module sel_sort_ctrl
    import sel_sort_pkg::*;
#(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_last_addr,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_ram_rd_en,
    output logic [SIZE_ADDR-1:0] o_ram_addr,
    input  logic [SIZE_DATA-1:0] i_ram_rdata,
    output logic                 o_ram_owner,
    output logic                 o_swap_start,
    output logic [SIZE_ADDR-1:0] o_swap_addr_i,
    output logic [SIZE_ADDR-1:0] o_swap_addr_smallest,
    input  logic                 i_swap_done
);

    state_t               state_q, state_d;
    logic [SIZE_ADDR-1:0] i_q, i_d;
    logic [SIZE_ADDR-1:0] j_q, j_d;
    logic [SIZE_ADDR-1:0] last_q, last_d;
    logic                 owner_q, owner_d;
    logic                 min_load, min_cmp;
    logic [SIZE_ADDR-1:0] min_addr;

    sel_sort_min_tracker #(
        .SIZE_ADDR (SIZE_ADDR),
        .SIZE_DATA (SIZE_DATA)
    ) u_min (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .load_i     (min_load),
        .cmp_i      (min_cmp),
        .data_i     (i_ram_rdata),
        .addr_i     (min_load ? i_q : j_q),
        .min_addr_o (min_addr)
    );

    // State and index registers. Reset abandons any sort in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            last_q  <= '0;
            owner_q <= OWNER_CTRL;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    // Next-state and output decode. The indices never pass last, so they cannot wrap
    // even when last is the highest address.
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        j_d          = j_q;
        last_d       = last_q;
        owner_d      = owner_q;
        o_done       = 1'b0;
        o_ram_rd_en  = 1'b0;
        o_ram_addr   = '0;
        o_swap_start = 1'b0;
        min_load     = 1'b0;
        min_cmp      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    last_d = i_last_addr;
                    i_d    = '0;
                    state_d = (i_last_addr != '0) ? ST_RD_I : ST_DONE;
                end
            end
            ST_RD_I: begin
                o_ram_rd_en = 1'b1;
                o_ram_addr  = i_q;
                j_d         = i_q + 1'b1;
                state_d     = ST_CAP_I;
            end
            ST_CAP_I: begin
                min_load = 1'b1;
                state_d  = ST_RD_J;
            end
            ST_RD_J: begin
                o_ram_rd_en = 1'b1;
                o_ram_addr  = j_q;
                state_d     = ST_CMP_J;
            end
            ST_CMP_J: begin
                min_cmp = 1'b1;
                if (j_q == last_q) begin
                    state_d = ST_DECIDE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = ST_RD_J;
                end
            end
            ST_DECIDE: begin
                if (min_addr != i_q) begin
                    o_swap_start = 1'b1;
                    owner_d      = OWNER_SWAP;
                    state_d      = ST_SWAP_WAIT;
                end else begin
                    state_d = ST_NEXT_I;
                end
            end
            ST_SWAP_WAIT: begin
                if (i_swap_done) begin
                    owner_d = OWNER_CTRL;
                    state_d = ST_NEXT_I;
                end
            end
            ST_NEXT_I: begin
                if (i_q == last_q - 1'b1) begin
                    state_d = ST_DONE;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = ST_RD_I;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy               = (state_q != ST_IDLE);
    assign o_ram_owner          = owner_q;
    assign o_swap_addr_i        = i_q;
    assign o_swap_addr_smallest = min_addr;

endmodule

// File: tb/tb_sel_sort_ctrl.sv
// Bench for sel_sort_ctrl. It includes a behavioural RAM, a fixed-latency swap unit, and a
// reference selection sort that predicts the swap sequence and the final RAM contents.
module tb_sel_sort_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          start_main = 1'b0, start_inj = 1'b0;
    logic [AW-1:0] i_last_addr = '0;
    logic [DW-1:0] i_ram_rdata = '0;
    logic          swap_done_m = 1'b0, done_inj_d = 1'b0, done_inj_r = 1'b0;
    wire           i_start     = start_main | start_inj;
    wire           i_swap_done = swap_done_m | done_inj_d | done_inj_r;
    logic          o_busy, o_done, o_ram_rd_en, o_ram_owner, o_swap_start;
    logic [AW-1:0] o_ram_addr, o_swap_addr_i, o_swap_addr_smallest;

    always #5 clk = ~clk;

    sel_sort_ctrl #(.SIZE_ADDR(AW), .SIZE_DATA(DW)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_last_addr(i_last_addr),
        .o_busy(o_busy), .o_done(o_done), .o_ram_rd_en(o_ram_rd_en), .o_ram_addr(o_ram_addr),
        .i_ram_rdata(i_ram_rdata), .o_ram_owner(o_ram_owner), .o_swap_start(o_swap_start),
        .o_swap_addr_i(o_swap_addr_i), .o_swap_addr_smallest(o_swap_addr_smallest),
        .i_swap_done(i_swap_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // RAM, swap unit and reference model state
    logic [DW-1:0] mem[N];
    logic [DW-1:0] init_arr[N];
    logic [DW-1:0] exp_final[N];
    logic [AW-1:0] exp_a[$], exp_b[$];
    logic [AW-1:0] run_last = '0;

    // RAM read port: request seen mid-cycle, data presented just after the next edge
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    always @(negedge clk) begin
        rd_req  = o_ram_rd_en && !o_ram_owner;
        rd_addr = o_ram_addr;
    end
    always @(posedge clk) begin
        #1;
        if (rd_req) i_ram_rdata = mem[rd_addr];
    end

    // Swap unit: exchanges the two words three cycles after launch, then pulses done
    int            swap_cnt = 0;
    logic [AW-1:0] sa = '0, sb = '0;
    logic [DW-1:0] st;
    always @(negedge clk) begin
        swap_done_m = 1'b0;
        if (!i_rst_n) begin
            swap_cnt = 0;
        end else if (swap_cnt > 0) begin
            swap_cnt--;
            if (swap_cnt == 0) begin
                st = mem[sa]; mem[sa] = mem[sb]; mem[sb] = st;
                swap_done_m = 1'b1;
            end
        end else if (o_swap_start) begin
            sa = o_swap_addr_i;
            sb = o_swap_addr_smallest;
            swap_cnt = 3;
        end
    end

    // Disturbance injector: spurious start and swap_done on the second read of a run (RD_J)
    logic disturb_en = 1'b0;
    int   dist_rd = 0;
    always @(negedge clk) begin
        start_inj  = 1'b0;
        done_inj_d = 1'b0;
        if (disturb_en && o_ram_rd_en) begin
            dist_rd++;
            if (dist_rd == 2) begin
                start_inj  = 1'b1;
                done_inj_d = 1'b1;
            end
        end
    end

    // Reference selection sort over the initial array.
    task automatic load_and_model(input int last);
        logic [DW-1:0] a[N];
        logic [DW-1:0] t;
        int m;
        exp_a.delete();
        exp_b.delete();
        a = init_arr;
        mem = init_arr;
        for (int i = 0; i < last; i++) begin
            m = i;
            for (int j = i + 1; j <= last; j++) if (a[j] < a[m]) m = j;
            if (m != i) begin
                exp_a.push_back(AW'(i));
                exp_b.push_back(AW'(m));
                t = a[i]; a[i] = a[m]; a[m] = t;
            end
        end
        exp_final = a;
        run_last = AW'(last);
    endtask

    // Per-cycle compare against the model
    int            rd_cnt = 0, swaps_obs = 0, done_cnt = 0;
    logic          prev_done = 1'b0;
    logic [AW-1:0] lat_a = '0, lat_b = '0;
    always @(negedge clk) begin
        if (i_rst_n) begin
            if (o_swap_start) begin
                swaps_obs++;
                lat_a = o_swap_addr_i;
                lat_b = o_swap_addr_smallest;
                if (exp_a.size() == 0) begin
                    check("swap_unexpected", 1, 0);
                end else begin
                    check("swap_addr_i", o_swap_addr_i, exp_a.pop_front());
                    check("swap_addr_smallest", o_swap_addr_smallest, exp_b.pop_front());
                end
            end
            if (o_ram_owner) begin
                check("rd_en_while_swap_owns", o_ram_rd_en, 0);
                check("swap_addr_hold", {o_swap_addr_i, o_swap_addr_smallest}, {lat_a, lat_b});
            end
            if (o_ram_rd_en) begin
                rd_cnt++;
                check("rd_addr_in_range", o_ram_addr <= run_last, 1);
            end
            if (o_done) begin
                done_cnt++;
                check("done_busy", o_busy, 1);
                check("done_single_cycle", prev_done, 0);
            end
            prev_done = o_done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic run_sort(input string tag, input int last, output int lat);
        int nexp;
        load_and_model(last);
        nexp = exp_a.size();
        rd_cnt = 0; swaps_obs = 0; done_cnt = 0; dist_rd = 0;
        @(negedge clk);
        i_last_addr = AW'(last);
        start_main = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge clk);
            start_main = 1'b0;
            i_last_addr = AW'(last + 3);
            lat++;
            if (o_done) break;
            check({tag, "_busy"}, o_busy, 1);
            if (lat > 3000) begin
                check({tag, "_timeout"}, 1, 0);
                break;
            end
        end
        @(negedge clk);
        check({tag, "_idle_after"}, o_busy, 0);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_swap_count"}, swaps_obs, nexp);
        check({tag, "_swaps_left"}, exp_a.size(), 0);
        for (int k = 0; k <= last; k++) check({tag, "_final_mem"}, mem[k], exp_final[k]);
    endtask

    int lat;
    int wait_cyc;

    initial begin
        init_arr = '{default: '0};
        repeat (3) @(negedge clk);
        check("rst_busy", o_busy, 0);
        check("rst_outs", {o_done, o_ram_rd_en, o_ram_owner, o_swap_start}, 0);
        check("rst_addrs", {o_ram_addr, o_swap_addr_i, o_swap_addr_smallest}, 0);
        i_rst_n = 1'b1;

        // Already sorted pair: no swap, done 7 cycles after accept
        init_arr = '{3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_sort("sorted2", 1, lat);
        check("sorted2_latency", lat, 7);
        check("sorted2_no_swap", swaps_obs, 0);

        // Reversed pair: one swap (0,1)
        init_arr = '{9, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_and_model(1);
        check("model_pair_a", exp_a[0], 0);
        check("model_pair_b", exp_b[0], 1);
        run_sort("rev2", 1, lat);
        check("rev2_mem0", mem[0], 2);
        check("rev2_mem1", mem[1], 9);

        // Five elements with a tie: the earlier index 1 must win
        init_arr = '{5, 1, 4, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_and_model(4);
        check("model5_nswaps", exp_a.size(), 4);
        check("model5_swaps", {exp_a[0], exp_b[0], exp_a[1], exp_b[1], exp_a[2], exp_b[2], exp_a[3], exp_b[3]},
              {4'd0, 4'd1, 4'd1, 4'd3, 4'd2, 4'd4, 4'd3, 4'd4});
        check("model5_final", {exp_final[0], exp_final[1], exp_final[2], exp_final[3], exp_final[4]},
              {8'd1, 8'd1, 8'd3, 8'd4, 8'd5});
        run_sort("tie5", 4, lat);

        // Single element: done on the next cycle, no reads, no swaps
        init_arr = '{6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_sort("one", 0, lat);
        check("one_latency", lat, 1);
        check("one_no_reads", rd_cnt, 0);
        check("one_no_swap", swaps_obs, 0);

        // Reset while the swap unit owns the RAM
        init_arr = '{9, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        load_and_model(1);
        @(negedge clk);
        i_last_addr = 4'd1;
        start_main = 1'b1;
        wait_cyc = 0;
        while (!o_ram_owner && wait_cyc < 100) begin
            @(negedge clk);
            start_main = 1'b0;
            wait_cyc++;
        end
        start_main = 1'b0;
        check("rstswap_reached_wait", o_ram_owner, 1);
        i_rst_n = 1'b0;
        #1;
        check("rstswap_busy", o_busy, 0);
        check("rstswap_ctrl", {o_done, o_ram_rd_en, o_ram_owner, o_swap_start}, 0);
        check("rstswap_addrs", {o_ram_addr, o_swap_addr_i, o_swap_addr_smallest}, 0);
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;
        done_inj_r = 1'b1;
        @(negedge clk);
        done_inj_r = 1'b0;
        check("rstswap_done_ignored", {o_busy, o_ram_owner}, 0);
        run_sort("after_rst", 1, lat);

        // Disturbed run: spurious start and swap_done while scanning
        init_arr = '{5, 1, 4, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        disturb_en = 1'b1;
        run_sort("disturbed", 4, lat);
        disturb_en = 1'b0;
        check("disturbed_hit_rdj", dist_rd >= 2, 1);

        // Full address range: last = 15 must not wrap the indices
        init_arr = '{200, 15, 15, 255, 0, 7, 99, 3, 3, 128, 1, 64, 2, 250, 0, 17};
        run_sort("full16", 15, lat);

        // Mid-sized arbitrary vector
        init_arr = '{8, 3, 3, 255, 0, 7, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
        run_sort("mix8", 7, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
